// File: rtl/sys_timer_multi.sv
// sys_timer_multi: free-running time base with a programmable prescaler and
// N_CMP one-shot compare channels that raise sticky interrupt flags.
//
// Build option: define SYS_TIMER_CAPTURE_EN to enable the cap_in timestamp
// capture path. Without it, cap_in is ignored and cap_value/cap_valid are 0.
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   enable              run prescaler/counter; 0 = hold
//   load_valid          load time_now from load_value (priority over increment)
//   load_value          new time value
//   cmp_wr/cmp_sel      write cmp_value into channel cmp_sel and arm it
//   cmp_value           compare value
//   irq_clr             per-channel clear of the sticky irq flags
//   cap_in              asynchronous capture strobe
//   time_now            current time
//   tick                one-cycle pulse when time_now shows an incremented value
//   irq                 sticky per-channel match flags
//   cap_value/cap_valid captured time and its one-cycle update strobe
module sys_timer_multi #(
    parameter int unsigned DIV_CYCLES = 100,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned N_CMP      = 4,
    localparam int unsigned SEL_W     = (N_CMP > 1) ? $clog2(N_CMP) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_value,
    input  logic             cmp_wr,
    input  logic [SEL_W-1:0] cmp_sel,
    input  logic [CNT_W-1:0] cmp_value,
    input  logic [N_CMP-1:0] irq_clr,
    input  logic             cap_in,
    output logic [CNT_W-1:0] time_now,
    output logic             tick,
    output logic [N_CMP-1:0] irq,
    output logic [CNT_W-1:0] cap_value,
    output logic             cap_valid
);

    localparam int unsigned PRE_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] time_q, time_d;
    logic             tick_q, tick_d;
    logic [N_CMP-1:0] irq_q, irq_d;
    logic [N_CMP-1:0] armed_q, armed_d;
    logic [CNT_W-1:0] cmp_q [N_CMP];
    logic [CNT_W-1:0] cmp_d [N_CMP];

    logic             term_c;
    logic [CNT_W-1:0] time_inc_c;
    logic [N_CMP-1:0] match_c;

    // Prescaler, counter and compare channel next-state logic
    always_comb begin
        term_c     = enable && (pre_q == PRE_W'(DIV_CYCLES - 1));
        time_inc_c = time_q + CNT_W'(1);
        pre_d      = pre_q;
        time_d     = time_q;
        tick_d     = 1'b0;
        irq_d      = irq_q;
        armed_d    = armed_q;
        cmp_d      = cmp_q;
        match_c    = '0;

        if (load_valid) begin
            time_d = load_value;
            pre_d  = '0;
        end else if (term_c) begin
            time_d = time_inc_c;
            pre_d  = '0;
            tick_d = 1'b1;
        end else if (enable) begin
            pre_d  = pre_q + PRE_W'(1);
        end

        // Per channel: clear < match (set wins) < write (re-arm wins)
        for (int i = 0; i < int'(N_CMP); i++) begin
            match_c[i] = term_c && !load_valid && armed_q[i] && (time_inc_c == cmp_q[i]);
            if (irq_clr[i]) begin
                irq_d[i] = 1'b0;
            end
            if (match_c[i]) begin
                irq_d[i]   = 1'b1;
                armed_d[i] = 1'b0;
            end
            // Out-of-range cmp_sel never equals a channel index, so it is ignored
            if (cmp_wr && (cmp_sel == SEL_W'(i))) begin
                cmp_d[i]   = cmp_value;
                armed_d[i] = 1'b1;
                irq_d[i]   = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q   <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
            irq_q   <= '0;
            armed_q <= '0;
            for (int i = 0; i < int'(N_CMP); i++) begin
                cmp_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            irq_q   <= irq_d;
            armed_q <= armed_d;
            for (int i = 0; i < int'(N_CMP); i++) begin
                cmp_q[i] <= cmp_d[i];
            end
        end
    end

    assign time_now = time_q;
    assign tick     = tick_q;
    assign irq      = irq_q;

`ifdef SYS_TIMER_CAPTURE_EN
    logic             cap_s1_q, cap_s2_q, cap_s3_q;
    logic [CNT_W-1:0] cap_value_q;
    logic             cap_valid_q;
    logic             cap_rise_c;

    // Rising edge of the synchronised strobe; s3 is the previous s2 value
    assign cap_rise_c = cap_s2_q && !cap_s3_q;

    // Two-flop synchroniser plus edge history and capture register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_s1_q    <= 1'b0;
            cap_s2_q    <= 1'b0;
            cap_s3_q    <= 1'b0;
            cap_value_q <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_s1_q    <= cap_in;
            cap_s2_q    <= cap_s1_q;
            cap_s3_q    <= cap_s2_q;
            cap_valid_q <= cap_rise_c;
            // time_q is the pre-increment value even on a term edge
            if (cap_rise_c) begin
                cap_value_q <= time_q;
            end
        end
    end

    assign cap_value = cap_value_q;
    assign cap_valid = cap_valid_q;
`else
    logic cap_in_unused;
    assign cap_in_unused = cap_in;
    assign cap_value     = '0;
    assign cap_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_sys_timer_multi.sv
// Self-checking bench for sys_timer_multi (DIV_CYCLES=100, CNT_W=8, N_CMP=4):
// a vector table for the main counting/compare flow plus directed sequences
// for clear/set races, write/match races, async reset and capture.
module tb_sys_timer_multi;

    localparam int unsigned DIV = 100;
    localparam int unsigned CW  = 8;
    localparam int unsigned NC  = 4;
`ifdef SYS_TIMER_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          load_valid;
    logic [CW-1:0] load_value;
    logic          cmp_wr;
    logic [1:0]    cmp_sel;
    logic [CW-1:0] cmp_value;
    logic [NC-1:0] irq_clr;
    logic          cap_in;
    logic [CW-1:0] time_now;
    logic          tick;
    logic [NC-1:0] irq;
    logic [CW-1:0] cap_value;
    logic          cap_valid;

    int checks;
    int errors;
    int tick_cnt;

    sys_timer_multi #(.DIV_CYCLES(DIV), .CNT_W(CW), .N_CMP(NC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_value (load_value),
        .cmp_wr     (cmp_wr),
        .cmp_sel    (cmp_sel),
        .cmp_value  (cmp_value),
        .irq_clr    (irq_clr),
        .cap_in     (cap_in),
        .time_now   (time_now),
        .tick       (tick),
        .irq        (irq),
        .cap_value  (cap_value),
        .cap_valid  (cap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          ld;
        logic [CW-1:0] ldv;
        logic          wr;
        logic [1:0]    sel;
        logic [CW-1:0] cv;
        logic [NC-1:0] clr;
        int            n;
        logic [CW-1:0] et;
        logic          etk;
        logic [NC-1:0] eirq;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (tick) tick_cnt++;
        end
    endtask

    task automatic clear_pulses();
        load_valid = 1'b0;
        cmp_wr     = 1'b0;
        irq_clr    = '0;
    endtask

    initial begin
        reset_n    = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        cmp_wr     = 1'b0;
        cmp_sel    = '0;
        cmp_value  = '0;
        irq_clr    = '0;
        cap_in     = 1'b0;
        checks     = 0;
        errors     = 0;
        tick_cnt   = 0;

        //          en ld ldv    wr sel cv     clr      n    et     etk eirq
        vecs[0]  = '{1, 0, 8'h00, 1, 1, 8'h05, 4'b0000, 99,  8'h00, 0, 4'b0000};
        vecs[1]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 1,   8'h01, 1, 4'b0000};
        vecs[2]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 1,   8'h01, 0, 4'b0000};
        vecs[3]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 399, 8'h05, 1, 4'b0010};
        vecs[4]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 1,   8'h05, 0, 4'b0010};
        vecs[5]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0010, 1,   8'h05, 0, 4'b0000};
        vecs[6]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 498, 8'h0A, 1, 4'b0000};
        vecs[7]  = '{1, 1, 8'hFF, 0, 0, 8'h00, 4'b0000, 1,   8'hFF, 0, 4'b0000};
        vecs[8]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 99,  8'hFF, 0, 4'b0000};
        vecs[9]  = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 1,   8'h00, 1, 4'b0000};
        vecs[10] = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 500, 8'h05, 1, 4'b0000};
        vecs[11] = '{1, 0, 8'h00, 1, 0, 8'h40, 4'b0000, 99,  8'h05, 0, 4'b0000};
        vecs[12] = '{1, 1, 8'h40, 0, 0, 8'h00, 4'b0000, 1,   8'h40, 0, 4'b0000};
        vecs[13] = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 99,  8'h40, 0, 4'b0000};
        vecs[14] = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 1,   8'h41, 1, 4'b0000};
        vecs[15] = '{0, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 50,  8'h41, 0, 4'b0000};
        vecs[16] = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 100, 8'h42, 1, 4'b0000};
        vecs[17] = '{1, 0, 8'h00, 1, 2, 8'h44, 4'b0000, 1,   8'h42, 0, 4'b0000};
        vecs[18] = '{1, 0, 8'h00, 1, 3, 8'h44, 4'b0000, 99,  8'h43, 1, 4'b0000};
        vecs[19] = '{1, 0, 8'h00, 0, 0, 8'h00, 4'b0000, 100, 8'h44, 1, 4'b1100};

        // Reset state, checked asynchronously before any clock edge
        #1 reset_n = 1'b0;
        #2;
        check("rst_time", 32'(time_now), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_cap_value", 32'(cap_value), 32'h0);
        check("rst_cap_valid", 32'(cap_valid), 32'h0);
        step(2);
        reset_n = 1'b1;

        // Table-driven main flow
        for (int i = 0; i < 20; i++) begin
            enable     = vecs[i].en;
            load_valid = vecs[i].ld;
            load_value = vecs[i].ldv;
            cmp_wr     = vecs[i].wr;
            cmp_sel    = vecs[i].sel;
            cmp_value  = vecs[i].cv;
            irq_clr    = vecs[i].clr;
            if (i == 0) tick_cnt = 0;
            step(1);
            clear_pulses();
            step(vecs[i].n - 1);
            check($sformatf("vec%0d_time", i), 32'(time_now), 32'(vecs[i].et));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].etk));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].eirq));
            if (i == 6) check("ticks_in_1000", 32'(tick_cnt), 32'd10);
        end

        // irq_clr on ch2 in the same cycle as its match: set wins
        cmp_wr = 1'b1; cmp_sel = 2'd2; cmp_value = 8'h45; irq_clr = 4'b1000;
        step(1);
        clear_pulses();
        check("rewrite_clear_irq", 32'(irq), 32'h0);
        step(98);
        irq_clr = 4'b0100;
        step(1);
        clear_pulses();
        check("clr_vs_match_time", 32'(time_now), 32'h45);
        check("clr_vs_match_irq", 32'(irq), 32'b0100);

        // cmp_wr on ch1 in the same cycle as its match: write wins, re-armed
        cmp_wr = 1'b1; cmp_sel = 2'd1; cmp_value = 8'h46;
        step(1);
        clear_pulses();
        step(98);
        cmp_wr = 1'b1; cmp_sel = 2'd1; cmp_value = 8'h50;
        step(1);
        clear_pulses();
        check("wr_vs_match_time", 32'(time_now), 32'h46);
        check("wr_vs_match_irq", 32'(irq), 32'b0100);
        step(1000);
        check("rearm_fire_time", 32'(time_now), 32'h50);
        check("rearm_fire_irq", 32'(irq), 32'b0110);

        // Asynchronous reset mid-count, then a full prescaler period from 0
        step(37);
        reset_n = 1'b0;
        #1;
        check("midrst_time", 32'(time_now), 32'h0);
        check("midrst_tick", 32'(tick), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        #1 reset_n = 1'b1;
        step(99);
        check("post_rst_99_time", 32'(time_now), 32'h0);
        step(1);
        check("post_rst_100_time", 32'(time_now), 32'h1);
        check("post_rst_100_tick", 32'(tick), 32'h1);
        check("post_rst_irq", 32'(irq), 32'h0);

        // Capture: hold time at 7 and raise cap_in
        enable = 1'b0; load_valid = 1'b1; load_value = 8'h07;
        step(1);
        clear_pulses();
        cap_in = 1'b1;
        step(1);
        check("cap_edge1_valid", 32'(cap_valid), 32'h0);
        step(1);
        check("cap_edge2_valid", 32'(cap_valid), 32'h0);
        step(1);
        check("cap_edge3_valid", 32'(cap_valid), CAP_EN ? 32'h1 : 32'h0);
        check("cap_edge3_value", 32'(cap_value), CAP_EN ? 32'h7 : 32'h0);
        step(1);
        check("cap_edge4_valid", 32'(cap_valid), 32'h0);
        cap_in = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
